// File: rtl/fc_layer_link_if.sv
// Producer/consumer link bundle for fc_layer_link: element handshake,
// busy chaining and the consumer input-buffer write port.
interface fc_layer_link_if #(
  parameter int datatype_size = 4,
  parameter int addr_width    = 9
);
  logic                     i_valid;
  logic [datatype_size-1:0] i_data;
  logic                     o_ready;
  logic                     o_busy;
  logic                     i_next_busy;
  logic                     o_ibuf_we;
  logic [datatype_size-1:0] o_ibuf_wr_data;
  logic [addr_width-1:0]    o_ibuf_addr;
  logic                     o_start;
  logic [15:0]              o_frame_cnt;

  // Environment side: producer plus consumer status.
  modport master (
    output i_valid, i_data, i_next_busy,
    input  o_ready, o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr,
           o_start, o_frame_cnt
  );

  // Link side.
  modport slave (
    input  i_valid, i_data, i_next_busy,
    output o_ready, o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr,
           o_start, o_frame_cnt
  );
endinterface

// File: rtl/fc_layer_link.sv
// Streams one frame of activations from a producer layer into the consumer's
// input buffer, then kicks the consumer with a single start pulse.
//
// state | meaning
// FILL  | accepting elements into the consumer input buffer
// WAIT  | frame complete, waiting for the consumer to go idle
// START | o_start high for this one cycle, frame counted
// ACK   | waiting for the consumer to report busy before refilling
module fc_layer_link #(
  parameter int datatype_size = 4,
  parameter int transfer_size = 500,
  parameter int addr_width    = $clog2(transfer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  fc_layer_link_if.slave       bus
);

  typedef enum logic [1:0] {FILL, WAIT, START, ACK} state_t;

  localparam logic [addr_width-1:0] last_addr = addr_width'(transfer_size - 1);

  state_t                   state;
  logic [addr_width-1:0]    ptr;
  logic                     ibuf_we;
  logic [datatype_size-1:0] ibuf_wr_data;
  logic [addr_width-1:0]    ibuf_addr;
  logic                     start;
  logic [15:0]              frame_cnt;
  logic                     accept;

  // Ready only while filling and the consumer is idle; held low during reset.
  assign bus.o_ready = (state == FILL) && !bus.i_next_busy && !rst;
  assign accept      = bus.i_valid && bus.o_ready;

  // In FILL the link is transparent to the consumer's busy so the producer
  // sees back-pressure; once a frame is complete the link itself is busy.
  assign bus.o_busy  = (state == FILL) ? bus.i_next_busy : 1'b1;

  assign bus.o_ibuf_we      = ibuf_we;
  assign bus.o_ibuf_wr_data = ibuf_wr_data;
  assign bus.o_ibuf_addr    = ibuf_addr;
  assign bus.o_start        = start;
  assign bus.o_frame_cnt    = frame_cnt;

  // Frame sequencer with registered write port, start pulse and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      ptr          <= '0;
      ibuf_we      <= 1'b0;
      ibuf_wr_data <= '0;
      ibuf_addr    <= '0;
      start        <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      ibuf_we <= 1'b0;
      start   <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            ibuf_we      <= 1'b1;
            ibuf_wr_data <= bus.i_data;
            ibuf_addr    <= ptr;
            if (ptr == last_addr) begin
              ptr   <= '0;
              state <= WAIT;
            end else begin
              ptr <= ptr + addr_width'(1);
            end
          end
        end
        WAIT: begin
          // Pulse and count are registered on entry so START is the pulse cycle,
          // giving o_start two cycles after the last accept.
          if (!bus.i_next_busy) begin
            start     <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= START;
          end
        end
        START: begin
          state <= ACK;
        end
        ACK: begin
          if (bus.i_next_busy) begin
            state <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
